imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words, and issues one word-write per instruction into the writable instruction-memory port. It holds the pipeline in reset (`cpu_run` low) until the image is fully loaded, so it sits between the host/debug byte link and the instruction memory, ahead of fetch.

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CSUM state and its trailer byte exist only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int IMEM_BYTES_DEFAULT = 160;
    localparam int HDR_BYTES          = 2;
    localparam int WORD_BYTES         = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } loader_state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic takes_bytes(loader_state_t s);
        return (s == HDR0) || (s == HDR1) || (s == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
            || (s == CSUM)
`endif
            ;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words.
// word_done_o fires in the cycle the 4th byte of a word is presented; word_o is valid then.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] sh_q, sh_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        idx_d = idx_q;
        sh_d  = sh_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_valid_i) begin
            idx_d = idx_q + 2'd1;
            sh_d  = {byte_i, sh_q[23:8]};
        end
    end

    assign word_done_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
    assign word_o      = {byte_i, sh_q};

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
            sh_q  <= '0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header word count, then little-endian words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [63:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             busy,
    output logic             cpu_run,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / WORD_BYTES);
    localparam int               LO_W      = 8 * (HDR_BYTES - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t    PAYLOAD_END = CSUM;
`else
    localparam loader_state_t    PAYLOAD_END = DONE;
`endif

    loader_state_t    state_q, state_d;
    logic [LO_W-1:0]  cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             wr_en_q, wr_en_d;
    logic [63:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             accept;
    logic             word_done;
    logic [31:0]      word;
    logic [CNT_W-1:0] hdr_count;

    assign in_ready  = takes_bytes(state_q);
    assign accept    = in_valid && in_ready;
    assign hdr_count = CNT_W'({in_data, cnt_lo_q});

    imem_word_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (state_q == HDR0),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (in_data),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        count_d   = count_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR0;
                    words_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            HDR0: begin
                if (accept) begin
                    cnt_lo_d = in_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d = PAYLOAD_END;
                    end else if (hdr_count > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                end
`endif
                // Address uses the pre-increment count so word N lands at byte 4*N.
                if (word_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {{(64 - CNT_W - 2){1'b0}}, words_q, 2'b00};
                    wr_data_d = word;
                    words_d   = words_q + CNT_W'(1);
                    if (words_q + CNT_W'(1) == count_q) begin
                        state_d = PAYLOAD_END;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_lo_q  <= '0;
            count_q   <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_lo_q  <= cnt_lo_d;
            count_q   <= count_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = words_q;
    assign busy         = in_ready;
    assign cpu_run      = (state_q == DONE);
    assign error        = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-level reference model plus directed and random loads.
// Builds with or without IMEM_LOADER_CHECKSUM_EN; the model follows the same define.
module tb_imem_loader;

    localparam int MEM_BYTES = 160;
    localparam int CNT_W     = 16;
    localparam int MAX_W     = MEM_BYTES / 4;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             start    = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data  = 8'h00;
    logic             in_ready;
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             busy;
    logic             cpu_run;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .cpu_run      (cpu_run),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: interprets accepted bytes by position within the load.
    bit          m_loading = 0, m_done = 0, m_err = 0, m_wr = 0;
    int          m_n = 0, m_cnt = 0, m_words = 0;
    logic [7:0]  m_xor = 8'h00;
    logic [63:0] m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    logic [7:0]  m_data[$];

    task automatic model_finish(input bit ok);
        m_loading = 0;
        m_done    = ok;
        m_err     = !ok;
    endtask

    task automatic model_payload_end();
`ifndef IMEM_LOADER_CHECKSUM_EN
        model_finish(1'b1);
`endif
    endtask

    task automatic model_step();
        int k;
        m_wr = 0;
        if (!m_loading) begin
            if (start) begin
                m_loading = 1; m_done = 0; m_err = 0;
                m_n = 0; m_words = 0; m_xor = 8'h00;
                m_data.delete();
            end
        end else if (in_valid) begin
            k = m_n - 2;
            m_n++;
            if (k == -2) begin
                m_cnt = int'(in_data);
            end else if (k == -1) begin
                m_cnt += 256 * int'(in_data);
                if (m_cnt > MAX_W) model_finish(1'b0);
                else if (m_cnt == 0) model_payload_end();
            end else if (k < 4 * m_cnt) begin
                m_data.push_back(in_data);
                m_xor ^= in_data;
                if (k % 4 == 3) begin
                    m_wr      = 1;
                    m_wr_addr = 64'(4 * (k / 4));
                    m_wr_data = {m_data[k], m_data[k-1], m_data[k-2], m_data[k-3]};
                    m_words++;
                    if (m_words == m_cnt) model_payload_end();
                end
            end else begin
                model_finish(in_data == m_xor);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_loading = 0; m_done = 0; m_err = 0; m_wr = 0;
            m_n = 0; m_cnt = 0; m_words = 0; m_xor = 8'h00;
            m_data.delete();
        end else begin
            model_step();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    logic [95:0] wlog[$];

    initial forever begin
        @(negedge clk);
        check("in_ready", in_ready, m_loading);
        check("busy", busy, m_loading);
        check("cpu_run", cpu_run, m_done);
        check("error", error, m_err);
        check("words_loaded", words_loaded, 64'(m_words));
        check("wr_en", wr_en, m_wr);
        if (m_wr) begin
            check("wr_addr", wr_addr, m_wr_addr);
            check("wr_data", wr_data, m_wr_data);
        end
        if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers
    logic [7:0] stim[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit rnd_start);
        int   budget;
        logic acc;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        if (rnd_start && $urandom_range(7) == 0) start = 1'b1;
        budget = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            start = 1'b0;
            if (acc === 1'b1) break;
            budget++;
            if (budget > 50) begin
                n_checks++;
                $display("FAIL byte_accept_timeout: byte 0x%0h not accepted, want accept within 50 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_stim(input int gap_pct, input bit rnd_start);
        foreach (stim[i]) send_byte(stim[i], gap_pct, rnd_start);
        in_valid = 1'b0;
    endtask

    task automatic stim_trailer(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x ^= stim[i];
        stim.push_back(corrupt ? (x ^ 8'h01) : x);
`else
        if (corrupt) stim = stim;
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_words", words_loaded, 0);
        reset_n = 1'b1;
        tick();

        // Two-word image
        wlog.delete();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h13, 8'h07, 8'hF0, 8'h00};
        stim_trailer(1'b0);
        pulse_start();
        send_stim(0, 0);
        check("t1_cpu_run_next_cycle", cpu_run, 1);
        repeat (2) tick();
        check("t1_nwrites", wlog.size(), 2);
        check("t1_w0_addr", wlog[0][95:32], 64'h0);
        check("t1_w0_data", wlog[0][31:0], 32'h0000_0513);
        check("t1_w1_addr", wlog[1][95:32], 64'h4);
        check("t1_w1_data", wlog[1][31:0], 32'h00F0_0713);
        check("t1_words", words_loaded, 2);
        check("t1_busy", busy, 0);

        // Empty image
        wlog.delete();
        stim = '{8'h00, 8'h00};
        stim_trailer(1'b0);
        pulse_start();
        send_stim(0, 0);
        tick();
        check("t2_cpu_run", cpu_run, 1);
        check("t2_nwrites", wlog.size(), 0);
        check("t2_words", words_loaded, 0);

        // Oversized count: 41 words exceeds 160 bytes
        wlog.delete();
        stim = '{8'h29, 8'h00};
        pulse_start();
        send_stim(0, 0);
        check("t3_error", error, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_cpu_run", cpu_run, 0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t3_nwrites", wlog.size(), 0);
        check("t3_error_sticky", error, 1);
        pulse_start();
        check("t3_restart_error", error, 0);
        check("t3_restart_busy", busy, 1);
        check("t3_restart_ready", in_ready, 1);
        stim = '{8'h00, 8'h00};
        stim_trailer(1'b0);
        send_stim(0, 0);
        tick();

        // One word with in_valid toggling
        wlog.delete();
        stim = '{8'h01, 8'h00, 8'h37, 8'h12, 8'hAB, 8'hCD};
        stim_trailer(1'b0);
        pulse_start();
        foreach (stim[i]) begin
            send_byte(stim[i], 0, 0);
            if (i == 5) begin
                check("t4_wr_en", wr_en, 1);
                check("t4_wr_addr", wr_addr, 64'h0);
                check("t4_wr_data", wr_data, 32'hCDAB_1237);
            end
            in_valid = 1'b0;
            tick();
        end
        tick();
        check("t4_nwrites", wlog.size(), 1);
        check("t4_cpu_run", cpu_run, 1);

        // Reset after 6 data bytes of a 3-word load
        wlog.delete();
        stim = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start();
        send_stim(0, 0);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check("t5_rst_in_ready", in_ready, 0);
        check("t5_rst_wr_en", wr_en, 0);
        check("t5_rst_wr_addr", wr_addr, 0);
        check("t5_rst_wr_data", wr_data, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_words", words_loaded, 0);
        repeat (3) tick();
        in_valid = 1'b0;
        reset_n  = 1'b1;
        check("t5_nwrites", wlog.size(), 1);
        check("t5_w0_data", wlog[0][31:0], 32'h4433_2211);
        tick();
        wlog.delete();
        stim = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        stim_trailer(1'b0);
        pulse_start();
        send_stim(0, 0);
        repeat (2) tick();
        check("t5_reload_nwrites", wlog.size(), 1);
        check("t5_reload_addr", wlog[0][95:32], 64'h0);
        check("t5_reload_data", wlog[0][31:0], 32'hEFBE_ADDE);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum trailer good and bad
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        pulse_start();
        send_stim(0, 0);
        check("t6_good_cpu_run", cpu_run, 1);
        check("t6_good_error", error, 0);
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        pulse_start();
        send_stim(0, 0);
        check("t6_bad_error", error, 1);
        check("t6_bad_cpu_run", cpu_run, 0);
`endif

        // Random loads with gaps, ignored start pulses and occasional overflow
        for (int n = 0; n < 25; n++) begin
            int cnt;
            cnt = ($urandom_range(3) == 0) ? int'($urandom_range(MAX_W + 2)) : int'($urandom_range(6));
            stim.delete();
            stim.push_back(8'(cnt));
            stim.push_back(8'(cnt >> 8));
            if (cnt <= MAX_W) begin
                for (int i = 0; i < 4 * cnt; i++) stim.push_back(8'($urandom));
                stim_trailer($urandom_range(4) == 0);
            end
            repeat ($urandom_range(3)) tick();
            pulse_start();
            send_stim(int'($urandom_range(60)), 1'b1);
            repeat (2) tick();
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
